// File: rtl/fft_demux_pkg.sv
// Shared types and helpers for the FFT sample demux and its frame counter.
package fft_demux_pkg;

  typedef enum logic {SEL_MANUAL = 1'b0, SEL_AUTO = 1'b1} sel_mode_e;

  localparam int MAX_OUT       = 64;
  localparam int DEF_NUM_OUT   = 16;
  localparam int DEF_FRAME_LEN = 2048;
  localparam int SEL_W         = $clog2(DEF_NUM_OUT);
  localparam int IDX_W         = $clog2(DEF_FRAME_LEN);

  // Lane-valid encoding; an out-of-range index yields all zeros.
  function automatic logic [MAX_OUT-1:0] onehot(input int unsigned idx, input int unsigned n);
    logic [MAX_OUT-1:0] v;
    v = '0;
    if (idx < n) v = MAX_OUT'(1) << idx;
    return v;
  endfunction

endpackage

// File: rtl/fft_frame_counter.sv
// Sample-in-frame counter with natural power-of-two wrap and boundary flags.
module fft_frame_counter
  import fft_demux_pkg::*;
#(
  parameter  int FRAME_LEN = DEF_FRAME_LEN,
  localparam int CNT_W     = $clog2(FRAME_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             is_first,
  output logic             is_last
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + 1'b1;
  end

  assign is_first = (cnt == '0);
  assign is_last  = (cnt == CNT_W'(FRAME_LEN - 1));

endmodule

// File: rtl/fft_demux_1xn.sv
// 1-to-N FFT sample demux: one output register stage, valid/ready, frame tags, flush.
module fft_demux_1xn
  import fft_demux_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int NUM_OUT    = DEF_NUM_OUT,
  parameter  int FRAME_LEN  = DEF_FRAME_LEN,
  localparam int LANE_W     = $clog2(NUM_OUT),
  localparam int CNT_W      = $clog2(FRAME_LEN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  mode_auto,
  input  logic [LANE_W-1:0]     data_sel,
  input  logic                  data_i_valid,
  output logic                  data_i_ready,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [NUM_OUT-1:0]    data_o_valid,
  input  logic [NUM_OUT-1:0]    data_o_ready,
  output logic                  data_o_last,
  output logic [CNT_W-1:0]      data_o_idx,
  output logic                  frame_done
);

  logic [CNT_W-1:0]  cnt;
  logic              is_first;
  logic              is_last;
  logic              acc;
  logic              xfer;
  sel_mode_e         mode_q;
  sel_mode_e         mode_eff;
  logic [LANE_W-1:0] lane;

  fft_frame_counter #(.FRAME_LEN(FRAME_LEN)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .inc      (xfer),
    .cnt      (cnt),
    .is_first (is_first),
    .is_last  (is_last)
  );

  // Ready is open when the stage is empty or is being emptied this cycle.
  assign acc          = |(data_o_valid & data_o_ready);
  assign data_i_ready = !clr && (!(|data_o_valid) || acc);
  assign xfer         = data_i_valid && data_i_ready;

  // The first sample of a frame already follows the mode being latched with it.
  always_comb begin
    // NOTE: defaults first so no path through this block can infer a latch.
    mode_eff = mode_q;
    lane     = data_sel;
    if (is_first) mode_eff = sel_mode_e'(mode_auto);
    if (mode_eff == SEL_AUTO) lane = cnt[LANE_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_o       <= '0;
      data_o_valid <= '0;
      data_o_last  <= 1'b0;
      data_o_idx   <= '0;
      frame_done   <= 1'b0;
      mode_q       <= SEL_MANUAL;
    end else if (clr) begin
      data_o_valid <= '0;
      data_o_last  <= 1'b0;
      frame_done   <= 1'b0;
      mode_q       <= SEL_MANUAL;
    end else begin
      frame_done <= acc && data_o_last;
      if (xfer) begin
        data_o       <= data_i;
        data_o_valid <= NUM_OUT'(onehot(32'(lane), NUM_OUT));
        data_o_idx   <= cnt;
        data_o_last  <= is_last;
        if (is_first) mode_q <= sel_mode_e'(mode_auto);
      end else if (acc) begin
        data_o_valid <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fft_demux_1xn.sv
// Randomized and directed self-checking bench for fft_demux_1xn against a transaction-level model.
module tb_fft_demux_1xn;

  localparam int DW  = 8;
  localparam int NO  = 16;
  localparam int FL  = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr;
  logic          mode_auto;
  logic [3:0]    data_sel;
  logic          data_i_valid;
  logic          data_i_ready;
  logic [DW-1:0] data_i;
  logic [DW-1:0] data_o;
  logic [NO-1:0] data_o_valid;
  logic [NO-1:0] data_o_ready;
  logic          data_o_last;
  logic [4:0]    data_o_idx;
  logic          frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: the sample sitting in the output stage, if any, plus frame position and mode.
  int            m_cnt;
  bit            m_mode;
  bit            m_pend;
  int            m_lane;
  logic [DW-1:0] m_data;
  int            m_idx;
  bit            m_last;
  bit            m_done;

  fft_demux_1xn #(.DATA_WIDTH(DW), .NUM_OUT(NO), .FRAME_LEN(FL)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .mode_auto    (mode_auto),
    .data_sel     (data_sel),
    .data_i_valid (data_i_valid),
    .data_i_ready (data_i_ready),
    .data_i       (data_i),
    .data_o       (data_o),
    .data_o_valid (data_o_valid),
    .data_o_ready (data_o_ready),
    .data_o_last  (data_o_last),
    .data_o_idx   (data_o_idx),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_mode = 0; m_pend = 0; m_lane = 0;
    m_data = '0; m_idx = 0; m_last = 0; m_done = 0;
  endtask

  task automatic check_outputs(input string pfx);
    check({pfx, ".valid"}, 64'(data_o_valid), m_pend ? 64'(1) << m_lane : 64'd0);
    check({pfx, ".done"},  64'(frame_done),   64'(m_done));
    if (m_pend) begin
      check({pfx, ".data"}, 64'(data_o),      64'(m_data));
      check({pfx, ".idx"},  64'(data_o_idx),  64'(m_idx));
      check({pfx, ".last"}, 64'(data_o_last), 64'(m_last));
    end
  endtask

  // One clock cycle: drive at posedge+1, check mid-cycle, advance the model, return at next posedge+1.
  task automatic step(input bit v, input logic [DW-1:0] d, input logic [3:0] s,
                      input bit m, input logic [NO-1:0] r, input bit c);
    bit exp_rdy, acc, xfer, use_auto;
    data_i_valid = v; data_i = d; data_sel = s; mode_auto = m; data_o_ready = r; clr = c;
    #3;
    check_outputs("cyc");
    acc     = m_pend && r[m_lane];
    exp_rdy = !c && (!m_pend || acc);
    check("ready", 64'(data_i_ready), 64'(exp_rdy));
    xfer = v && exp_rdy;
    if (c) begin
      m_cnt = 0; m_pend = 0; m_mode = 0; m_done = 0; m_last = 0;
    end else begin
      m_done = acc && m_last;
      if (xfer) begin
        use_auto = (m_cnt == 0) ? m : m_mode;
        if (m_cnt == 0) m_mode = m;
        m_lane = use_auto ? (m_cnt % NO) : int'(s);
        m_data = d;
        m_idx  = m_cnt;
        m_last = (m_cnt == FL - 1);
        m_pend = 1;
        m_cnt  = (m_cnt + 1) % FL;
      end else if (acc) begin
        m_pend = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; clr = 0; mode_auto = 0; data_sel = '0;
    data_i_valid = 0; data_i = '0; data_o_ready = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst.valid", 64'(data_o_valid), 64'd0);
    check("rst.data",  64'(data_o),       64'd0);
    check("rst.idx",   64'(data_o_idx),   64'd0);
    check("rst.last",  64'(data_o_last),  64'd0);
    check("rst.done",  64'(frame_done),   64'd0);
    rst_n = 1'b1;

    // Manual lanes 3,15,0,7.
    begin
      logic [3:0]    sels [4];
      logic [NO-1:0] vexp [4];
      sels = '{4'd3, 4'd15, 4'd0, 4'd7};
      vexp = '{16'h0008, 16'h8000, 16'h0001, 16'h0080};
      for (int i = 0; i < 4; i++) begin
        step(1, DW'(8'hA1 + i), sels[i], 0, '1, 0);
        check("man.valid", 64'(data_o_valid), 64'(vexp[i]));
        check("man.idx",   64'(data_o_idx),   64'(i));
      end
    end

    // Flush, then one auto frame of 32 back-to-back samples.
    step(0, '0, '0, 0, '1, 1);
    check("clr.valid", 64'(data_o_valid), 64'd0);
    for (int k = 0; k < FL; k++) begin
      step(1, DW'(k), '0, 1, '1, 0);
      check("auto.valid", 64'(data_o_valid), 64'(1) << (k % NO));
      check("auto.last",  64'(data_o_last),  64'(k == FL - 1));
    end
    step(0, '0, '0, 1, '1, 0);
    check("auto.done", 64'(frame_done), 64'd1);
    step(0, '0, '0, 1, '1, 0);
    check("auto.done_pulse", 64'(frame_done), 64'd0);

    // Backpressure on lane 5 (manual frame).
    step(1, 8'h55, 4'd5, 0, '1, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 8'h66, 4'd6, 0, ~(NO'(1) << 5), 0);
      check("bp.hold", 64'(data_o), 64'h55);
    end
    step(1, 8'h66, 4'd6, 0, '1, 0);
    check("bp.next", 64'(data_o), 64'h66);

    // Auto frame up to idx 20, then clr with valid input.
    step(0, '0, '0, 0, '1, 1);
    for (int k = 0; k < 20; k++) step(1, DW'(k), '0, 1, '1, 0);
    step(1, 8'hEE, '0, 1, '1, 1);
    check("clr.drop", 64'(data_o_valid), 64'd0);
    step(1, 8'h77, 4'd9, 1, '1, 0);
    check("clr.lane0", 64'(data_o_valid), 64'd1);
    check("clr.idx0",  64'(data_o_idx),   64'd0);

    // Mode toggled mid-frame: model decides where it takes effect.
    for (int k = 0; k < 2 * FL; k++)
      step(1, DW'($urandom), 4'($urandom), (k % FL) >= 10 ? 1'b0 : 1'b1, '1, 0);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      logic [NO-1:0] r;
      r = ($urandom_range(0, 3) == 0) ? NO'($urandom) : '1;
      step($urandom_range(0, 3) != 0, DW'($urandom), 4'($urandom),
           ($urandom_range(0, 15) == 0) ? ~mode_auto : mode_auto, r,
           $urandom_range(0, 39) == 0);
    end

    // Async reset while lane 2 holds a sample.
    step(0, '0, '0, 0, '1, 1);
    step(1, 8'h22, 4'd2, 0, '0, 0);
    check("ar.pre", 64'(data_o_valid), 64'h4);
    #2 rst_n = 1'b0;
    #1;
    check("ar.valid", 64'(data_o_valid), 64'd0);
    check("ar.data",  64'(data_o),       64'd0);
    check("ar.last",  64'(data_o_last),  64'd0);
    check("ar.idx",   64'(data_o_idx),   64'd0);
    check("ar.done",  64'(frame_done),   64'd0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1, 8'h31, 4'd4, 1, '1, 0);
    check("ar.idx0", 64'(data_o_idx), 64'd0);
    step(0, '0, '0, 1, '1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
